sha1_pad_stream: RTL and testbench



---
 rtl/sha_pad_pkg.sv | 27 ++
 rtl/sha_pad_len_calc.sv | 32 +++
 rtl/sha1_pad_stream.sv | 135 +++++++++++++
 tb/tb_sha1_pad_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pad_pkg.sv
// Shared types and helpers for the Merkle-Damgard message padder.
// Holds the FSM state encoding, the 0x80 marker word and the partial-word byte mask.
package sha_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSG,
    ST_MARK,
    ST_ZERO,
    ST_LEN
  } state_t;

  localparam logic [31:0] PAD_MARK = 32'h8000_0000;

  // Keeps the k leading (big-endian) message bytes of a partial last word.
  function automatic logic [31:0] last_word_mask(input logic [1:0] k);
    logic [31:0] m;
    case (k)
      2'd1:    m = 32'hFF00_0000;
      2'd2:    m = 32'hFFFF_0000;
      2'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sha_pad_len_calc.sv
// Padding arithmetic: pad bytes, input/output word counts and bit length from message size.
// Purely combinational; no handshake.
module sha_pad_len_calc #(
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_BYTES   = 8
) (
  input  logic [31:0] i_message_size,
  output logic [31:0] o_pad_len,
  output logic [31:0] o_in_words,
  output logic [31:0] o_out_words,
  output logic [63:0] o_bit_len
);

  localparam logic [31:0] BB       = 32'(BLOCK_BYTES);
  localparam logic [31:0] BB2      = 32'(2 * BLOCK_BYTES);
  localparam logic [31:0] LIMIT    = 32'(BLOCK_BYTES - LEN_BYTES);
  localparam logic [31:0] BW       = 32'(BLOCK_BYTES / 4);
  localparam logic [31:0] BW2      = 32'(BLOCK_BYTES / 2);

  logic [31:0] w_rem;
  logic        w_fits;

  assign w_rem  = i_message_size % BB;
  assign w_fits = (w_rem < LIMIT);

  assign o_pad_len  = w_fits ? (BB - w_rem) : (BB2 - w_rem);
  assign o_in_words = {2'b00, i_message_size[31:2]} + {31'd0, |i_message_size[1:0]};
  // Total is size rounded down to a block boundary plus one or two whole blocks.
  assign o_out_words = {2'b00, i_message_size[31:2]} - {2'b00, w_rem[31:2]} + (w_fits ? BW : BW2);
  assign o_bit_len   = {29'd0, i_message_size, 3'd0};

endmodule

// File: rtl/sha1_pad_stream.sv
// Streaming SHA-1 style message padder: message words, 0x80 marker, zero fill, bit-length field.
// One registered output stage; generated words and input acceptance stall while the output is held.
module sha1_pad_stream #(
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_BYTES   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] message_size,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_block_last,
  output logic        out_msg_last,
  output logic [31:0] padding_length,
  output logic        busy
);
  import sha_pad_pkg::*;

  localparam logic [31:0] LW      = 32'(LEN_BYTES / 4);
  localparam logic [15:0] BLK_END = 16'(BLOCK_BYTES / 4 - 1);

  state_t      r_state;
  logic [31:0] r_pad_len, r_in_left, r_out_left, r_out_data;
  logic [63:0] r_bit_len;
  logic [1:0]  r_k;
  logic [15:0] r_blk_idx;
  logic        r_busy, r_out_valid, r_out_blast, r_out_mlast;

  logic [31:0] w_pad_len, w_in_words, w_out_words, w_out_left_nx, w_len_word, w_msg_word;
  logic [31:0] w_emit_data;
  logic [63:0] w_bit_len;
  logic        w_adv, w_in_fire, w_start_ok, w_last_in, w_emit;
  state_t      w_next_fill;

  sha_pad_len_calc #(
    .BLOCK_BYTES(BLOCK_BYTES),
    .LEN_BYTES  (LEN_BYTES)
  ) u_len_calc (
    .i_message_size(message_size),
    .o_pad_len     (w_pad_len),
    .o_in_words    (w_in_words),
    .o_out_words   (w_out_words),
    .o_bit_len     (w_bit_len)
  );

  assign w_adv         = !r_out_valid || out_ready;
  assign in_ready      = (r_state == ST_MSG) && w_adv;
  assign w_in_fire     = in_valid && in_ready;
  assign w_start_ok    = start && !r_busy && (r_state == ST_IDLE);
  assign w_out_left_nx = r_out_left - 32'd1;
  assign w_next_fill   = (w_out_left_nx > LW) ? ST_ZERO : ST_LEN;
  assign w_last_in     = (r_in_left == 32'd1);

  // Length words are emitted MSW first; remaining count doubles as the word index from the LSW.
  assign w_len_word = (w_out_left_nx == 32'd0) ? r_bit_len[31:0]  :
                      (w_out_left_nx == 32'd1) ? r_bit_len[63:32] : 32'd0;
  assign w_msg_word = (w_last_in && r_k != 2'd0) ?
                      ((in_data & last_word_mask(r_k)) | (PAD_MARK >> {r_k, 3'b000})) : in_data;

  always_comb begin
    w_emit      = 1'b0;
    w_emit_data = 32'd0;
    case (r_state)
      ST_MSG:  begin w_emit = w_in_fire; w_emit_data = w_msg_word; end
      ST_MARK: begin w_emit = w_adv;     w_emit_data = PAD_MARK;   end
      ST_ZERO: begin w_emit = w_adv;     w_emit_data = 32'd0;      end
      ST_LEN:  begin w_emit = w_adv;     w_emit_data = w_len_word; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pad_len   <= 32'd0;
      r_in_left   <= 32'd0;
      r_out_left  <= 32'd0;
      r_bit_len   <= 64'd0;
      r_k         <= 2'd0;
      r_blk_idx   <= 16'd0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_blast <= 1'b0;
      r_out_mlast <= 1'b0;
    end else begin
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_emit_data;
        r_out_blast <= (r_blk_idx == BLK_END);
        r_out_mlast <= (r_out_left == 32'd1);
        r_out_left  <= w_out_left_nx;
        r_blk_idx   <= (r_blk_idx == BLK_END) ? 16'd0 : r_blk_idx + 16'd1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (r_out_valid && out_ready && r_out_mlast) r_busy <= 1'b0;

      case (r_state)
        ST_IDLE: if (w_start_ok) begin
          r_pad_len  <= w_pad_len;
          r_in_left  <= w_in_words;
          r_out_left <= w_out_words;
          r_bit_len  <= w_bit_len;
          r_k        <= message_size[1:0];
          r_blk_idx  <= 16'd0;
          r_busy     <= 1'b1;
          r_state    <= (message_size == 32'd0) ? ST_MARK : ST_MSG;
        end
        ST_MSG: if (w_in_fire) begin
          r_in_left <= r_in_left - 32'd1;
          if (w_last_in) r_state <= (r_k == 2'd0) ? ST_MARK : w_next_fill;
        end
        ST_MARK: if (w_adv) r_state <= w_next_fill;
        ST_ZERO: if (w_adv) r_state <= w_next_fill;
        ST_LEN:  if (w_adv && r_out_left == 32'd1) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_block_last = r_out_blast;
  assign out_msg_last   = r_out_mlast;
  assign padding_length = r_pad_len;
  assign busy           = r_busy;

endmodule

// File: tb/tb_sha1_pad_stream.sv
// Bench for sha1_pad_stream: a 64/8 and a 128/16 instance checked against a byte-level padding model.
module tb_sha1_pad_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, start, in_valid, out_ready;
  logic [31:0] message_size, in_data;

  logic        a_in_ready, a_out_valid, a_blast, a_mlast, a_busy;
  logic [31:0] a_out_data, a_pad;
  logic        b_in_ready, b_out_valid, b_blast, b_mlast, b_busy;
  logic [31:0] b_out_data, b_pad;

  logic        d_in_ready, d_out_valid, d_blast, d_mlast, d_busy;
  logic [31:0] d_out_data, d_pad;

  sha1_pad_stream u_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .message_size(message_size),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
    .out_block_last(a_blast), .out_msg_last(a_mlast), .padding_length(a_pad), .busy(a_busy)
  );

  sha1_pad_stream #(.BLOCK_BYTES(128), .LEN_BYTES(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .message_size(message_size),
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
    .out_block_last(b_blast), .out_msg_last(b_mlast), .padding_length(b_pad), .busy(b_busy)
  );

  assign d_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign d_out_valid = sel ? b_out_valid : a_out_valid;
  assign d_out_data  = sel ? b_out_data  : a_out_data;
  assign d_blast     = sel ? b_blast     : a_blast;
  assign d_mlast     = sel ? b_mlast     : a_mlast;
  assign d_busy      = sel ? b_busy      : a_busy;
  assign d_pad       = sel ? b_pad       : a_pad;

  int checks = 0;
  int errors = 0;
  logic [7:0]  msg_q[$];
  logic [31:0] got_q[$];

  task automatic gen_msg(input int n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom));
  endtask

  // Pads msg_q byte-by-byte, streams it through the selected instance and checks every word.
  task automatic run_msg(input logic s, input int ready_mode, input logic mid_start,
                         input logic [7:0] junk, output int pad_exp);
    int bb, lb, bw, size, nin, nexp, ip, op, cyc;
    logic [7:0]  e[$];
    logic [31:0] exp_w[$];
    logic [31:0] words[$];
    longint unsigned bl;
    logic stalled, h_blast, h_mlast, eb, em;
    logic [31:0] h_data;
    bb = s ? 128 : 64;
    lb = s ? 16 : 8;
    bw = bb / 4;
    size = msg_q.size();
    foreach (msg_q[i]) e.push_back(msg_q[i]);
    e.push_back(8'h80);
    while ((e.size() % bb) != bb - lb) e.push_back(8'h00);
    bl = longint'(size) * 8;
    for (int j = lb - 1; j >= 0; j--) e.push_back((j < 8) ? 8'(bl >> (8 * j)) : 8'h00);
    for (int i = 0; i < e.size() / 4; i++) exp_w.push_back({e[4*i], e[4*i+1], e[4*i+2], e[4*i+3]});
    nexp = exp_w.size();
    pad_exp = e.size() - size;
    nin = (size + 3) / 4;
    for (int i = 0; i < nin; i++) begin
      logic [31:0] w;
      for (int b = 0; b < 4; b++) w[31-8*b -: 8] = (4*i + b < size) ? msg_q[4*i+b] : junk;
      words.push_back(w);
    end
    got_q.delete();

    sel = s;
    @(negedge clk);
    start = 1'b1; message_size = size; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; #1;
    checks++;
    if (d_busy !== 1'b1 || d_pad !== 32'(pad_exp)) begin
      errors++;
      $display("FAIL start_latch size=%0d: busy=%b pad=%0d, required busy=1 pad=%0d", size, d_busy, d_pad, pad_exp);
    end

    ip = 0; op = 0; cyc = 0; stalled = 1'b0;
    h_data = '0; h_blast = 1'b0; h_mlast = 1'b0;
    while (op < nexp && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'($urandom % 2);
        1:       out_ready = 1'b1;
        default: out_ready = 1'(cyc % 2);
      endcase
      in_valid = (ip < nin) && ($urandom % 4 != 0);
      in_data  = (ip < nin) ? words[ip] : $urandom;
      start    = mid_start && ($urandom % 3 == 0);
      message_size = 32'd7;
      #1;
      if (mid_start && d_out_valid && d_mlast && out_ready) start = 1'b1;
      if (stalled) begin
        checks++;
        if (d_out_valid !== 1'b1 || d_out_data !== h_data || d_blast !== h_blast || d_mlast !== h_mlast) begin
          errors++;
          $display("FAIL hold word %0d: v=%b data=%h bl=%b ml=%b, required v=1 data=%h bl=%b ml=%b",
                   op, d_out_valid, d_out_data, d_blast, d_mlast, h_data, h_blast, h_mlast);
        end
      end
      checks++;
      if (d_in_ready === 1'b1 && ip >= nin) begin
        errors++;
        $display("FAIL over_accept: in_ready=1 after %0d of %0d words", ip, nin);
      end
      if (d_out_valid === 1'b1 && out_ready) begin
        eb = (op % bw == bw - 1);
        em = (op == nexp - 1);
        checks++;
        if (d_out_data !== exp_w[op] || d_blast !== eb || d_mlast !== em) begin
          errors++;
          $display("FAIL word %0d size=%0d: data=%h bl=%b ml=%b, required data=%h bl=%b ml=%b",
                   op, size, d_out_data, d_blast, d_mlast, exp_w[op], eb, em);
        end
        got_q.push_back(d_out_data);
        op++;
      end
      stalled = (d_out_valid === 1'b1) && !out_ready;
      h_data = d_out_data; h_blast = d_blast; h_mlast = d_mlast;
      if (in_valid && d_in_ready === 1'b1) ip++;
    end
    if (op < nexp) begin
      checks++; errors++;
      $display("FAIL timeout size=%0d: got %0d words, required %0d", size, op, nexp);
    end

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if (d_busy !== 1'b0 || d_out_valid !== 1'b0 || d_pad !== 32'(pad_exp) || ip != nin) begin
      errors++;
      $display("FAIL end_state size=%0d: busy=%b v=%b pad=%0d in=%0d, required busy=0 v=0 pad=%0d in=%0d",
               size, d_busy, d_out_valid, d_pad, ip, pad_exp, nin);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_out_valid, a_blast, a_mlast, a_busy, a_in_ready, b_out_valid, b_busy, b_in_ready} !== 8'd0 ||
        a_out_data !== 32'd0 || a_pad !== 32'd0 || b_out_data !== 32'd0 || b_pad !== 32'd0) begin
      errors++;
      $display("FAIL reset: a v=%b d=%h pad=%0d busy=%b rdy=%b, required all zero", a_out_valid, a_out_data, a_pad, a_busy, a_in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_size0();
    int p;
    logic [31:0] w;
    gen_msg(0);
    run_msg(1'b0, 1, 1'b0, 8'h00, p);
    w = (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx;
    checks++;
    if (a_pad !== 32'd64 || got_q.size() != 16 || w !== 32'h8000_0000) begin
      errors++;
      $display("FAIL size0: pad=%0d words=%0d first=%h, required 64 16 80000000", a_pad, got_q.size(), w);
    end
  endtask

  task automatic test_size3();
    int p;
    logic [31:0] w0, w15;
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 0, 1'b0, 8'h99, p);
    w0  = (got_q.size() > 0)  ? got_q[0]  : 32'hxxxx_xxxx;
    w15 = (got_q.size() > 15) ? got_q[15] : 32'hxxxx_xxxx;
    checks++;
    if (a_pad !== 32'd61 || w0 !== 32'h6162_6380 || w15 !== 32'h0000_0018 || got_q.size() != 16) begin
      errors++;
      $display("FAIL size3: pad=%0d w0=%h w15=%h n=%0d, required 61 61626380 00000018 16", a_pad, w0, w15, got_q.size());
    end
  endtask

  task automatic test_size55_56();
    int p;
    logic [31:0] wa, wb;
    gen_msg(55);
    run_msg(1'b0, 0, 1'b0, 8'h5A, p);
    wa = (got_q.size() > 13) ? got_q[13] : 32'hxxxx_xxxx;
    wb = (got_q.size() > 15) ? got_q[15] : 32'hxxxx_xxxx;
    checks++;
    if (a_pad !== 32'd9 || wa[7:0] !== 8'h80 || wb !== 32'h0000_01B8 || got_q.size() != 16) begin
      errors++;
      $display("FAIL size55: pad=%0d w13=%h w15=%h n=%0d, required 9 ......80 000001b8 16", a_pad, wa, wb, got_q.size());
    end
    gen_msg(56);
    run_msg(1'b0, 1, 1'b0, 8'h00, p);
    wa = (got_q.size() > 14) ? got_q[14] : 32'hxxxx_xxxx;
    wb = (got_q.size() > 31) ? got_q[31] : 32'hxxxx_xxxx;
    checks++;
    if (a_pad !== 32'd72 || wa !== 32'h8000_0000 || wb !== 32'h0000_01C0 || got_q.size() != 32) begin
      errors++;
      $display("FAIL size56: pad=%0d w14=%h w31=%h n=%0d, required 72 80000000 000001c0 32", a_pad, wa, wb, got_q.size());
    end
  endtask

  task automatic test_stall_restart();
    int p;
    gen_msg(64);
    run_msg(1'b0, 2, 1'b1, 8'h00, p);
    checks++;
    if (a_pad !== 32'd64 || got_q.size() != 32) begin
      errors++;
      $display("FAIL size64_stall: pad=%0d n=%0d, required 64 32", a_pad, got_q.size());
    end
  endtask

  task automatic test_wide_block();
    int p;
    logic [31:0] w28, w29, w30, w31;
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b1, 0, 1'b0, 8'hEE, p);
    w28 = (got_q.size() > 31) ? got_q[28] : 32'hxxxx_xxxx;
    w29 = (got_q.size() > 31) ? got_q[29] : 32'hxxxx_xxxx;
    w30 = (got_q.size() > 31) ? got_q[30] : 32'hxxxx_xxxx;
    w31 = (got_q.size() > 31) ? got_q[31] : 32'hxxxx_xxxx;
    checks++;
    if (b_pad !== 32'd125 || got_q.size() != 32 || (w28 | w29 | w30) !== 32'd0 || w31 !== 32'h0000_0018) begin
      errors++;
      $display("FAIL wide_size3: pad=%0d n=%0d w28..30=%h %h %h w31=%h, required 125 32 0 0 0 00000018",
               b_pad, got_q.size(), w28, w29, w30, w31);
    end
  endtask

  task automatic test_random();
    int p;
    for (int it = 0; it < 10; it++) begin
      gen_msg($urandom_range(0, 300));
      run_msg(1'($urandom % 2), $urandom_range(0, 2), 1'($urandom % 2), 8'($urandom), p);
    end
  endtask

  task automatic test_reset_abort();
    int p;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; message_size = 32'd100; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_pad !== 32'd0 || a_out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: v=%b busy=%b rdy=%b pad=%0d d=%h, required all zero",
               a_out_valid, a_busy, a_in_ready, a_pad, a_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gen_msg(20);
    run_msg(1'b0, 0, 1'b0, 8'h00, p);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; message_size = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_size0();
    test_size3();
    test_size55_56();
    test_stall_restart();
    test_wide_block();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
